// File: rtl/lcd_win_addr_ctrl.sv
// LCD controller front end: decodes SPI command/data bytes into a clamped address
// window and a stream of RGB565 pixel writes that walk that window.
module lcd_win_addr_ctrl #(
  parameter int unsigned H_RES = 480,
  parameter int unsigned V_RES = 272
) (
  input  logic        i_spi_clk,
  input  logic        i_rst_n,
  input  logic        i_spi_cs,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  input  logic        i_dc,
  output logic [7:0]  o_cmd,
  output logic [15:0] o_col_start,
  output logic [15:0] o_col_end,
  output logic [15:0] o_row_start,
  output logic [15:0] o_row_end,
  output logic        o_wr_en,
  output logic [15:0] o_wr_x,
  output logic [15:0] o_wr_y,
  output logic [15:0] o_wr_data,
  output logic        o_disp_on,
  output logic        o_win_err
);

  localparam logic [15:0] COL_MAX = 16'(H_RES - 1);
  localparam logic [15:0] ROW_MAX = 16'(V_RES - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {IDLE, CASET_P, RASET_P, RAMWR} state_t;

  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] col_start_q, col_start_d, col_end_q, col_end_d;
  logic [15:0] row_start_q, row_start_d, row_end_q, row_end_d;
  logic [31:0] shadow_q, shadow_d;
  logic [1:0]  pidx_q, pidx_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d, wr_data_q, wr_data_d;
  logic        disp_on_q, disp_on_d;
  logic        win_err_q, win_err_d;

  logic [31:0] param_word;
  logic [15:0] new_start, new_end;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    col_start_d = col_start_q;
    col_end_d   = col_end_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    shadow_d    = shadow_q;
    pidx_d      = pidx_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    x_d         = x_q;
    y_d         = y_q;
    wr_en_d     = 1'b0;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_data_d   = wr_data_q;
    disp_on_d   = disp_on_q;
    win_err_d   = win_err_q;
    param_word  = {shadow_q[23:0], i_byte};
    new_start   = 16'd0;
    new_end     = 16'd0;

    if (i_spi_cs) begin
      // Deselect drops partial transfers but keeps the command context.
      phase_d  = 1'b0;
      pidx_d   = 2'd0;
      shadow_d = 32'd0;
    end else if (i_byte_vld && !i_dc) begin
      cmd_d    = i_byte;
      pidx_d   = 2'd0;
      phase_d  = 1'b0;
      shadow_d = 32'd0;
      case (i_byte)
        CMD_CASET: state_d = CASET_P;
        CMD_RASET: state_d = RASET_P;
        CMD_RAMWR: begin
          state_d = RAMWR;
          x_d     = col_start_q;
          y_d     = row_start_q;
        end
        CMD_DISPON: begin
          state_d   = IDLE;
          disp_on_d = 1'b1;
        end
        CMD_DISPOFF: begin
          state_d   = IDLE;
          disp_on_d = 1'b0;
        end
        CMD_SWRESET: begin
          state_d     = IDLE;
          col_start_d = 16'd0;
          col_end_d   = COL_MAX;
          row_start_d = 16'd0;
          row_end_d   = ROW_MAX;
          disp_on_d   = 1'b0;
          win_err_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end else if (i_byte_vld) begin
      case (state_q)
        CASET_P, RASET_P: begin
          shadow_d = param_word;
          pidx_d   = 2'(pidx_q + 2'd1);
          if (pidx_q == 2'd3) begin
            shadow_d = 32'd0;
            pidx_d   = 2'd0;
            state_d  = IDLE;
            if (state_q == CASET_P) begin
              new_start   = clamp(param_word[31:16], COL_MAX);
              new_end     = clamp(param_word[15:0], COL_MAX);
              col_start_d = new_start;
              col_end_d   = new_end;
              win_err_d   = (new_start > new_end) || (row_start_q > row_end_q);
            end else begin
              new_start   = clamp(param_word[31:16], ROW_MAX);
              new_end     = clamp(param_word[15:0], ROW_MAX);
              row_start_d = new_start;
              row_end_d   = new_end;
              win_err_d   = (col_start_q > col_end_q) || (new_start > new_end);
            end
          end
        end
        RAMWR: begin
          if (!phase_q) begin
            hi_d    = i_byte;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            // An inverted window swallows pixels so the counters never run away.
            if (!win_err_q) begin
              wr_en_d   = 1'b1;
              wr_x_d    = x_q;
              wr_y_d    = y_q;
              wr_data_d = {hi_q, i_byte};
              if (x_q == col_end_q) begin
                x_d = col_start_q;
                y_d = (y_q == row_end_q) ? row_start_q : y_q + 16'd1;
              end else begin
                x_d = x_q + 16'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= 8'd0;
      col_start_q <= 16'd0;
      col_end_q   <= COL_MAX;
      row_start_q <= 16'd0;
      row_end_q   <= ROW_MAX;
      shadow_q    <= 32'd0;
      pidx_q      <= 2'd0;
      phase_q     <= 1'b0;
      hi_q        <= 8'd0;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      wr_en_q     <= 1'b0;
      wr_x_q      <= 16'd0;
      wr_y_q      <= 16'd0;
      wr_data_q   <= 16'd0;
      disp_on_q   <= 1'b0;
      win_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      col_start_q <= col_start_d;
      col_end_q   <= col_end_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
      shadow_q    <= shadow_d;
      pidx_q      <= pidx_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wr_en_q     <= wr_en_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_data_q   <= wr_data_d;
      disp_on_q   <= disp_on_d;
      win_err_q   <= win_err_d;
    end
  end

  assign o_cmd       = cmd_q;
  assign o_col_start = col_start_q;
  assign o_col_end   = col_end_q;
  assign o_row_start = row_start_q;
  assign o_row_end   = row_end_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_x      = wr_x_q;
  assign o_wr_y      = wr_y_q;
  assign o_wr_data   = wr_data_q;
  assign o_disp_on   = disp_on_q;
  assign o_win_err   = win_err_q;

endmodule

// File: tb/tb_lcd_win_addr_ctrl.sv
// Directed bench for lcd_win_addr_ctrl: window commands, pixel streaming, chip-select
// and reset corner cases, with every pixel write logged and compared by hand values.
module tb_lcd_win_addr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        vld = 1'b0;
  logic [7:0]  byt = 8'd0;
  logic        dc = 1'b0;
  logic [7:0]  cmd;
  logic [15:0] col_start, col_end, row_start, row_end;
  logic        wr_en;
  logic [15:0] wr_x, wr_y, wr_data;
  logic        disp_on, win_err;

  int total = 0;
  int bad = 0;

  logic [15:0] lx[$];
  logic [15:0] ly[$];
  logic [15:0] ld[$];

  lcd_win_addr_ctrl dut (
    .i_spi_clk   (clk),
    .i_rst_n     (rst_n),
    .i_spi_cs    (cs),
    .i_byte_vld  (vld),
    .i_byte      (byt),
    .i_dc        (dc),
    .o_cmd       (cmd),
    .o_col_start (col_start),
    .o_col_end   (col_end),
    .o_row_start (row_start),
    .o_row_end   (row_end),
    .o_wr_en     (wr_en),
    .o_wr_x      (wr_x),
    .o_wr_y      (wr_y),
    .o_wr_data   (wr_data),
    .o_disp_on   (disp_on),
    .o_win_err   (win_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      lx.push_back(wr_x);
      ly.push_back(wr_y);
      ld.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic d, input logic [7:0] b);
    @(negedge clk);
    vld = 1'b1;
    dc  = d;
    byt = b;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic c(input logic [7:0] b);
    send(1'b0, b);
  endtask

  task automatic d(input logic [7:0] b);
    send(1'b1, b);
  endtask

  task automatic clear_log();
    lx.delete();
    ly.delete();
    ld.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'h00);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'h0);
    chk({tag, "_wr_x"}, 32'(wr_x), 32'h0);
    chk({tag, "_wr_y"}, 32'(wr_y), 32'h0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'h0);
    chk({tag, "_disp"}, 32'(disp_on), 32'h0);
    chk({tag, "_err"}, 32'(win_err), 32'h0);
    chk({tag, "_cs"}, 32'(col_start), 32'd0);
    chk({tag, "_ce"}, 32'(col_end), 32'd479);
    chk({tag, "_rs"}, 32'(row_start), 32'd0);
    chk({tag, "_re"}, 32'(row_end), 32'd271);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Window 2..3 x 5..6, ten data bytes -> five pixels, fifth wraps to origin
    clear_log();
    c(8'h2A); d(8'h00); d(8'h02); d(8'h00); d(8'h03);
    chk("caset_cs", 32'(col_start), 32'd2);
    chk("caset_ce", 32'(col_end), 32'd3);
    c(8'h2B); d(8'h00); d(8'h05); d(8'h00); d(8'h06);
    chk("raset_rs", 32'(row_start), 32'd5);
    chk("raset_re", 32'(row_end), 32'd6);
    c(8'h2C);
    chk("ramwr_cmd", 32'(cmd), 32'h2C);
    for (int i = 0; i < 10; i++) d(8'(8'h10 + i));
    chk("win_nwr", lx.size(), 5);
    if (lx.size() == 5) begin
      chk("win_p0", {lx[0], ly[0]}, {16'd2, 16'd5});
      chk("win_p1", {lx[1], ly[1]}, {16'd3, 16'd5});
      chk("win_p2", {lx[2], ly[2]}, {16'd2, 16'd6});
      chk("win_p3", {lx[3], ly[3]}, {16'd3, 16'd6});
      chk("win_p4", {lx[4], ly[4]}, {16'd2, 16'd5});
      chk("win_d0", 32'(ld[0]), 32'h1011);
      chk("win_d4", 32'(ld[4]), 32'h1819);
    end

    // SWRESET, then chip-select mid pixel and a strobe under deselect
    c(8'h01);
    chk("swr_ce", 32'(col_end), 32'd479);
    chk("swr_rs", 32'(row_start), 32'd0);
    clear_log();
    c(8'h2C);
    d(8'hAB);
    @(negedge clk); cs = 1'b1;
    @(negedge clk); cs = 1'b0;
    d(8'h12); d(8'h34);
    @(negedge clk); cs = 1'b1; vld = 1'b1; dc = 1'b1; byt = 8'h99;
    @(negedge clk); cs = 1'b0; vld = 1'b0;
    d(8'h56); d(8'h78);
    chk("cs_nwr", lx.size(), 2);
    if (lx.size() == 2) begin
      chk("cs_p0", {lx[0], ly[0]}, {16'd0, 16'd0});
      chk("cs_d0", 32'(ld[0]), 32'h1234);
      chk("cs_p1", {lx[1], ly[1]}, {16'd1, 16'd0});
      chk("cs_d1", 32'(ld[1]), 32'h5678);
    end
    chk("cs_cmd_kept", 32'(cmd), 32'h2C);

    // Column clamp to the last pixel
    clear_log();
    c(8'h2A); d(8'h01); d(8'hF4); d(8'h02); d(8'h00);
    chk("clamp_cs", 32'(col_start), 32'd479);
    chk("clamp_ce", 32'(col_end), 32'd479);
    c(8'h2C); d(8'hAA); d(8'hBB);
    chk("clamp_nwr", lx.size(), 1);
    if (lx.size() == 1) begin
      chk("clamp_p", {lx[0], ly[0]}, {16'd479, 16'd0});
      chk("clamp_d", 32'(ld[0]), 32'hAABB);
    end

    // Inverted window flags an error and blocks writes
    clear_log();
    c(8'h2A); d(8'h00); d(8'h10); d(8'h00); d(8'h05);
    chk("err_set", 32'(win_err), 32'h1);
    c(8'h2C); d(8'h01); d(8'h02); d(8'h03); d(8'h04);
    chk("err_nwr", lx.size(), 0);
    c(8'h2A); d(8'h00); d(8'h00); d(8'h00); d(8'h05);
    chk("err_clr", 32'(win_err), 32'h0);

    // Partial CASET leaves the window alone; DISPON then SWRESET
    c(8'h2A); d(8'h00); d(8'h02);
    c(8'h29);
    chk("part_cs", 32'(col_start), 32'd0);
    chk("part_ce", 32'(col_end), 32'd5);
    chk("dispon", 32'(disp_on), 32'h1);
    c(8'h01);
    chk("swr2_ce", 32'(col_end), 32'd479);
    chk("swr2_disp", 32'(disp_on), 32'h0);
    chk("swr2_cmd", 32'(cmd), 32'h01);

    // Row clamp, then data in IDLE is ignored
    clear_log();
    c(8'h2B); d(8'h01); d(8'h00); d(8'h01); d(8'h20);
    chk("rclamp_rs", 32'(row_start), 32'd256);
    chk("rclamp_re", 32'(row_end), 32'd271);
    c(8'h00);
    d(8'h11); d(8'h22);
    chk("idle_nwr", lx.size(), 0);
    chk("idle_cmd", 32'(cmd), 32'h00);

    // Reset between the high and low byte of a pixel
    clear_log();
    c(8'h29);
    c(8'h2A); d(8'h00); d(8'h01); d(8'h00); d(8'h01);
    c(8'h2C); d(8'hC3);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk); rst_n = 1'b1;
    d(8'h3C);
    chk("mid_nwr", lx.size(), 0);
    chk("mid_wr_en", 32'(wr_en), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
